mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master to one-slave pipelined Wishbone arbiter sharing the single memory port between the instruction fetch module (IF master) and the load/store module (LS master). It sits between both masters and the memory slave. It grants the bus for whole Wishbone cycles (`cyc` high to `cyc` low), and muxes address, control and write data from the granted master. It steers `ack` and `stall` back to that master only.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, Wishbone address width.
- `DATA_WIDTH`, 32, Wishbone data width; `sel` width is `DATA_WIDTH/8`.

Ports (IF master has no write path):
- `clk_i`  in  1  Single clock; all logic rising-edge.
- `rst_i`  in  1  Reset, synchronous, active-low.
- `if_wb_adr_i`, `if_wb_stb_i`, `if_wb_cyc_i`  in  ADDR_WIDTH/1/1  IF master request.
- `if_wb_dat_o`  out  DATA_WIDTH  Read data to IF master.
- `if_wb_ack_o`, `if_wb_stall_o`  out  1/1  IF master response.
- `ls_wb_adr_i`, `ls_wb_dat_i`, `ls_wb_sel_i`, `ls_wb_we_i`, `ls_wb_stb_i`, `ls_wb_cyc_i`  in  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1/1/1  LS master request.
- `ls_wb_dat_o`  out  DATA_WIDTH  Read data to LS master.
- `ls_wb_ack_o`, `ls_wb_stall_o`  out  1/1  LS master response.
- `wb_adr_o`, `wb_dat_o`, `wb_sel_o`, `wb_we_o`, `wb_stb_o`, `wb_cyc_o`  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1/1/1  Slave request.
- `wb_dat_i`, `wb_ack_i`, `wb_stall_i`  in  DATA_WIDTH/1/1  Slave response.

## Operation
- Registered grant FSM, states IDLE, GRANT_IF, GRANT_LS. `last_grant` register (IF/LS).
- Transitions are evaluated every edge. Both IDLE and a released grant use the same rule.
  - IDLE: select a requester per policy. If no `cyc` is high, stay IDLE.
  - GRANT_x, `x_cyc_i`=1: stay.
  - GRANT_x, `x_cyc_i`=0 (release):
    - If the other master's `cyc`=1, hand off to the other master directly; no IDLE cycle.
    - Else if `x_cyc_i` is low, go IDLE.
- Policy (see Configuration) applies only when both `cyc` are high at a decision point.
- Slave outputs are combinational muxes of the granted master.
  - The IF master drives `wb_we_o`=0, `wb_sel_o`=all ones, `wb_dat_o`=0.
  - In IDLE, all slave outputs are 0.
- Granted master: `ack_o`=`wb_ack_i`, `stall_o`=`wb_stall_i`.
- Non-granted master (or either master in IDLE): `ack_o`=0, `stall_o`=1.
- `wb_dat_i` is broadcast to both `if_wb_dat_o` and `ls_wb_dat_o` unqualified; masters qualify it with `ack`.
- Grant is never revoked while the granted `cyc` is high. Masters must hold `cyc` until all outstanding acks return; the arbiter does not count outstanding transfers.
- `last_grant` updates on every transition into a GRANT state.

## Timing
- Reset (`rst_i`=0 at an edge): state=IDLE, `last_grant`=LS.
- After reset, all slave outputs are 0, both `ack_o`=0, and both `stall_o`=1.
- Arbitration latency:
  - `cyc` rising in IDLE at edge N gives the grant after edge N+1. `wb_cyc_o`/`wb_stb_o` follow from that cycle, and the master's `stall_o` drops the same cycle.
  - A master's `stb` issued while it is ungranted sees `stall_o`=1 and is held by the master per Wishbone rules.
- Handoff: granted `cyc` low at edge N, other `cyc` high, gives the other master's grant after edge N+1. That is one dead cycle where `wb_cyc_o` follows the released master (0).
- Reset mid-transfer: state goes to IDLE at the reset edge regardless of outstanding acks. `wb_cyc_o` drops the next cycle, and late `wb_ack_i` is dropped (no master is granted).
- Simultaneous release and new request by the same master (`cyc` low for exactly one cycle): treated as release; re-arbitrated.

## Configuration
- `MEM_ARBITER_ROUND_ROBIN_EN` defined: on a tie, grant the master opposite `last_grant`.
- Undefined: fixed priority, LS always wins ties. `last_grant` is still maintained but unused.

## Test plan
- Reset: drive `rst_i`=0 for 2 cycles with both `cyc`=1 -> `wb_cyc_o`=0, `if_wb_stall_o`=`ls_wb_stall_o`=1, `ack`s=0.
- IF alone: IF `cyc`/`stb` at `adr`=0x100, slave data 0xDEADBEEF -> grant one cycle later, `wb_adr_o`=0x100, `wb_we_o`=0, `if_wb_ack_o` pulses with `if_wb_dat_o`=0xDEADBEEF, `ls_wb_ack_o`=0 throughout.
- LS write: `ls_wb_adr_i`=0x200, `ls_wb_dat_i`=0x12345678, `ls_wb_sel_i`=0x3, `we`=1 -> slave sees identical values and `ls_wb_ack_o` on `wb_ack_i`.
- Tie, fixed priority: both `cyc` raised the same cycle from IDLE, each doing 3 reads -> LS granted first. IF granted one cycle after LS `cyc` falls. IF `stall_o`=1 until then.
- Tie, round-robin (macro defined): both masters hold back-to-back requests for 4 cycles each -> grants alternate LS, IF, LS, IF.
- Slave stall and reset mid-cycle: `wb_stall_i`=1 for 3 cycles during an LS grant -> `ls_wb_stall_o` mirrors it and IF stays stalled. Reset asserted mid-transfer -> IDLE next edge, a late `wb_ack_i` reaches neither master.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (IF, LS) to one-slave pipelined Wishbone arbiter; MEM_ARBITER_ROUND_ROBIN_EN selects round-robin ties (else LS wins).
// Latency: grant registered one edge after cyc is seen; slave request path and ack/stall return are combinational.
// Backpressure: ungranted masters see stall=1, granted master sees the slave's stall; grant held until its cyc drops.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   if_wb_adr_i,
  input  logic                    if_wb_stb_i,
  input  logic                    if_wb_cyc_i,
  output logic [DATA_WIDTH-1:0]   if_wb_dat_o,
  output logic                    if_wb_ack_o,
  output logic                    if_wb_stall_o,
  input  logic [ADDR_WIDTH-1:0]   ls_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   ls_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] ls_wb_sel_i,
  input  logic                    ls_wb_we_i,
  input  logic                    ls_wb_stb_i,
  input  logic                    ls_wb_cyc_i,
  output logic [DATA_WIDTH-1:0]   ls_wb_dat_o,
  output logic                    ls_wb_ack_o,
  output logic                    ls_wb_stall_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_stall_i
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GRANT_IF = 2'd1;
  localparam logic [1:0] GRANT_LS = 2'd2;
  localparam logic       LAST_IF  = 1'b0;
  localparam logic       LAST_LS  = 1'b1;

  logic [1:0] state, state_nxt;
  logic [1:0] arb_pick;
  logic       last_grant, last_grant_nxt;
  logic       tie_to_ls;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  assign tie_to_ls = (last_grant == LAST_IF);
`else
  assign tie_to_ls = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      last_grant <= LAST_LS;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Decision shared by IDLE and a released grant; the releasing master's cyc is already low.
  always_comb begin
    arb_pick = IDLE;
    if (if_wb_cyc_i && ls_wb_cyc_i) begin
      arb_pick = tie_to_ls ? GRANT_LS : GRANT_IF;
    end else if (ls_wb_cyc_i) begin
      arb_pick = GRANT_LS;
    end else if (if_wb_cyc_i) begin
      arb_pick = GRANT_IF;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GRANT_IF: if (!if_wb_cyc_i) state_nxt = arb_pick;
      GRANT_LS: if (!ls_wb_cyc_i) state_nxt = arb_pick;
      default:  state_nxt = arb_pick;
    endcase
    last_grant_nxt = last_grant;
    if (state_nxt == GRANT_IF) last_grant_nxt = LAST_IF;
    if (state_nxt == GRANT_LS) last_grant_nxt = LAST_LS;
  end

  always_comb begin
    wb_adr_o      = '0;
    wb_dat_o      = '0;
    wb_sel_o      = '0;
    wb_we_o       = 1'b0;
    wb_stb_o      = 1'b0;
    wb_cyc_o      = 1'b0;
    if_wb_ack_o   = 1'b0;
    if_wb_stall_o = 1'b1;
    ls_wb_ack_o   = 1'b0;
    ls_wb_stall_o = 1'b1;
    case (state)
      GRANT_IF: begin
        wb_adr_o      = if_wb_adr_i;
        wb_sel_o      = '1;
        wb_stb_o      = if_wb_stb_i;
        wb_cyc_o      = if_wb_cyc_i;
        if_wb_ack_o   = wb_ack_i;
        if_wb_stall_o = wb_stall_i;
      end
      GRANT_LS: begin
        wb_adr_o      = ls_wb_adr_i;
        wb_dat_o      = ls_wb_dat_i;
        wb_sel_o      = ls_wb_sel_i;
        wb_we_o       = ls_wb_we_i;
        wb_stb_o      = ls_wb_stb_i;
        wb_cyc_o      = ls_wb_cyc_i;
        ls_wb_ack_o   = wb_ack_i;
        ls_wb_stall_o = wb_stall_i;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; masters qualify it with their own ack.
  assign if_wb_dat_o = wb_dat_i;
  assign ls_wb_dat_o = wb_dat_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, tie sequence, randomized run against an ownership model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int O_NONE = 0;
  localparam int O_IF   = 1;
  localparam int O_LS   = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] if_wb_adr_i;
  logic          if_wb_stb_i, if_wb_cyc_i;
  logic [DW-1:0] if_wb_dat_o;
  logic          if_wb_ack_o, if_wb_stall_o;
  logic [AW-1:0] ls_wb_adr_i;
  logic [DW-1:0] ls_wb_dat_i;
  logic [3:0]    ls_wb_sel_i;
  logic          ls_wb_we_i, ls_wb_stb_i, ls_wb_cyc_i;
  logic [DW-1:0] ls_wb_dat_o;
  logic          ls_wb_ack_o, ls_wb_stall_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_stb_o, wb_cyc_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i, wb_stall_i;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_wb_adr_i(if_wb_adr_i), .if_wb_stb_i(if_wb_stb_i), .if_wb_cyc_i(if_wb_cyc_i),
    .if_wb_dat_o(if_wb_dat_o), .if_wb_ack_o(if_wb_ack_o), .if_wb_stall_o(if_wb_stall_o),
    .ls_wb_adr_i(ls_wb_adr_i), .ls_wb_dat_i(ls_wb_dat_i), .ls_wb_sel_i(ls_wb_sel_i),
    .ls_wb_we_i(ls_wb_we_i), .ls_wb_stb_i(ls_wb_stb_i), .ls_wb_cyc_i(ls_wb_cyc_i),
    .ls_wb_dat_o(ls_wb_dat_o), .ls_wb_ack_o(ls_wb_ack_o), .ls_wb_stall_o(ls_wb_stall_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
  );

  always #5 clk_i = ~clk_i;

  // Ownership model: a holder keeps the bus while its cyc is high; otherwise choose among requesters.
  int m_own  = O_NONE;
  int m_last = O_LS;

  function automatic int tie_winner(input int last);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    return (last == O_LS) ? O_IF : O_LS;
`else
    return O_LS;
`endif
  endfunction

  always @(posedge clk_i) begin
    int pick;
    if (!rst_i) begin
      m_own  <= O_NONE;
      m_last <= O_LS;
    end else if (!((m_own == O_IF && if_wb_cyc_i) || (m_own == O_LS && ls_wb_cyc_i))) begin
      if (if_wb_cyc_i && ls_wb_cyc_i) pick = tie_winner(m_last);
      else if (ls_wb_cyc_i)          pick = O_LS;
      else if (if_wb_cyc_i)          pick = O_IF;
      else                           pick = O_NONE;
      m_own <= pick;
      if (pick != O_NONE) m_last <= pick;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for a given bus owner and the currently driven inputs.
  task automatic check_all(input int own);
    logic is_if, is_ls;
    is_if = (own == O_IF);
    is_ls = (own == O_LS);
    chk("wb_cyc_o", 64'(wb_cyc_o), 64'(is_if ? if_wb_cyc_i : is_ls ? ls_wb_cyc_i : 1'b0));
    chk("wb_stb_o", 64'(wb_stb_o), 64'(is_if ? if_wb_stb_i : is_ls ? ls_wb_stb_i : 1'b0));
    chk("wb_adr_o", 64'(wb_adr_o), 64'(is_if ? if_wb_adr_i : is_ls ? ls_wb_adr_i : 32'h0));
    chk("wb_dat_o", 64'(wb_dat_o), 64'(is_ls ? ls_wb_dat_i : 32'h0));
    chk("wb_sel_o", 64'(wb_sel_o), 64'(is_if ? 4'hF : is_ls ? ls_wb_sel_i : 4'h0));
    chk("wb_we_o", 64'(wb_we_o), 64'(is_ls ? ls_wb_we_i : 1'b0));
    chk("if_ack", 64'(if_wb_ack_o), 64'(is_if ? wb_ack_i : 1'b0));
    chk("if_stall", 64'(if_wb_stall_o), 64'(is_if ? wb_stall_i : 1'b1));
    chk("ls_ack", 64'(ls_wb_ack_o), 64'(is_ls ? wb_ack_i : 1'b0));
    chk("ls_stall", 64'(ls_wb_stall_o), 64'(is_ls ? wb_stall_i : 1'b1));
    chk("if_dat", 64'(if_wb_dat_o), 64'(wb_dat_i));
    chk("ls_dat", 64'(ls_wb_dat_o), 64'(wb_dat_i));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic rst, ic, is, lc, ls, ack, stall;
    int   own;
  } vec_t;
  vec_t vecs [21];

  task automatic setv(input int i, input logic [6:0] b, input int own);
    vecs[i] = '{b[6], b[5], b[4], b[3], b[2], b[1], b[0], own};
  endtask

  initial begin
    // bits: rst ic is lc ls ack stall ; own = owner during that cycle
    setv(0,  7'b0_1_1_1_1_0_0, O_NONE);
    setv(1,  7'b1_1_1_0_0_0_0, O_NONE);
    setv(2,  7'b1_1_1_0_0_0_0, O_IF);
    setv(3,  7'b1_1_0_0_0_1_0, O_IF);
    setv(4,  7'b1_0_0_0_0_0_0, O_IF);
    setv(5,  7'b1_0_0_1_1_0_0, O_NONE);
    setv(6,  7'b1_0_0_1_1_0_0, O_LS);
    setv(7,  7'b1_0_0_1_0_1_0, O_LS);
    setv(8,  7'b1_0_0_0_0_0_0, O_LS);
    setv(9,  7'b1_0_0_1_1_0_1, O_NONE);
    setv(10, 7'b1_1_1_1_1_0_1, O_LS);
    setv(11, 7'b1_1_1_1_1_0_1, O_LS);
    setv(12, 7'b1_1_1_1_1_0_0, O_LS);
    setv(13, 7'b1_1_0_1_0_1_0, O_LS);
    setv(14, 7'b1_1_1_0_0_0_0, O_LS);
    setv(15, 7'b1_1_1_0_0_0_0, O_IF);
    setv(16, 7'b1_1_1_1_1_0_0, O_IF);
    setv(17, 7'b0_1_1_1_1_0_0, O_IF);
    setv(18, 7'b1_1_0_0_0_1_0, O_NONE);
    setv(19, 7'b1_0_0_0_0_0_0, O_IF);
    setv(20, 7'b1_0_0_0_0_0_0, O_NONE);

    rst_i = 1'b0;
    if_wb_adr_i = 32'h100; if_wb_stb_i = 1'b1; if_wb_cyc_i = 1'b1;
    ls_wb_adr_i = 32'h200; ls_wb_dat_i = 32'h12345678; ls_wb_sel_i = 4'h3;
    ls_wb_we_i = 1'b1; ls_wb_stb_i = 1'b1; ls_wb_cyc_i = 1'b1;
    wb_dat_i = 32'hDEADBEEF; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
    step();

    for (int i = 0; i < 21; i++) begin
      rst_i       = vecs[i].rst;
      if_wb_cyc_i = vecs[i].ic;
      if_wb_stb_i = vecs[i].is;
      ls_wb_cyc_i = vecs[i].lc;
      ls_wb_stb_i = vecs[i].ls;
      wb_ack_i    = vecs[i].ack;
      wb_stall_i  = vecs[i].stall;
      @(negedge clk_i);
      check_all(vecs[i].own);
      step();
    end

    // Tie from IDLE: both raise cyc together; LS wins (last grant was IF), IF follows after one dead cycle.
    if_wb_adr_i = 32'h300; ls_wb_adr_i = 32'h400; ls_wb_we_i = 1'b0;
    if_wb_cyc_i = 1'b1; if_wb_stb_i = 1'b1; ls_wb_cyc_i = 1'b1; ls_wb_stb_i = 1'b1;
    @(negedge clk_i);
    chk("tie_idle_cyc", 64'(wb_cyc_o), 64'(1'b0));
    step();
    for (int k = 0; k < 3; k++) begin
      wb_ack_i = (k > 0);
      @(negedge clk_i);
      chk("tie_ls_adr", 64'(wb_adr_o), 64'h400);
      chk("tie_ls_stall", 64'(ls_wb_stall_o), 64'(1'b0));
      chk("tie_if_stall", 64'(if_wb_stall_o), 64'(1'b1));
      step();
    end
    ls_wb_cyc_i = 1'b0; ls_wb_stb_i = 1'b0; wb_ack_i = 1'b1;
    @(negedge clk_i);
    chk("tie_dead_cyc", 64'(wb_cyc_o), 64'(1'b0));
    chk("tie_dead_if_stall", 64'(if_wb_stall_o), 64'(1'b1));
    chk("tie_dead_ls_ack", 64'(ls_wb_ack_o), 64'(1'b1));
    step();
    wb_ack_i = 1'b0;
    @(negedge clk_i);
    chk("tie_if_adr", 64'(wb_adr_o), 64'h300);
    chk("tie_if_granted", 64'(if_wb_stall_o), 64'(1'b0));
    chk("tie_if_cyc", 64'(wb_cyc_o), 64'(1'b1));
    if_wb_cyc_i = 1'b0; if_wb_stb_i = 1'b0;
    step();
    step();

    // Randomized traffic, including occasional resets, checked against the ownership model.
    for (int n = 0; n < 800; n++) begin
      rst_i = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 3) == 0) if_wb_cyc_i = ~if_wb_cyc_i;
      if ($urandom_range(0, 3) == 0) ls_wb_cyc_i = ~ls_wb_cyc_i;
      if_wb_stb_i = 1'($urandom);
      ls_wb_stb_i = 1'($urandom);
      if_wb_adr_i = $urandom;
      ls_wb_adr_i = $urandom;
      ls_wb_dat_i = $urandom;
      ls_wb_sel_i = 4'($urandom);
      ls_wb_we_i  = 1'($urandom);
      wb_dat_i    = $urandom;
      wb_ack_i    = 1'($urandom);
      wb_stall_i  = 1'($urandom);
      @(negedge clk_i);
      check_all(m_own);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
